// File: rtl/fe_carry.sv
// Carry-propagation stage for ed25519 field elements (10 limbs, radix 2^25.5).
// Performs one signed, rounded carry per clock: limbs 0..9, then limb 0 again.
module fe_carry #(
    parameter int LIMB_W = 32,
    parameter int INT_W  = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [10*LIMB_W-1:0]  f,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LIMB_W-1:0]  h
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic signed [INT_W-1:0] HalfEven = INT_W'(1) <<< 25;
    localparam logic signed [INT_W-1:0] HalfOdd  = INT_W'(1) <<< 24;

    state_t                  r_state;
    logic [3:0]              r_step;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [INT_W-1:0] r_limb     [10];
    logic signed [INT_W-1:0] w_limb_nxt [10];

    logic [3:0]              w_idx;
    logic [3:0]              w_nxt;
    logic                    w_even;
    logic signed [INT_W-1:0] w_sel;
    logic signed [INT_W-1:0] w_round;
    logic signed [INT_W-1:0] w_c;
    logic signed [INT_W-1:0] w_kept;
    logic signed [INT_W-1:0] w_add;
    logic                    w_unused;

    // Step 10 revisits limb 0; the limb-9 carry wraps to limb 0 scaled by 19.
    always_comb begin
        w_idx   = (r_step == 4'd10) ? 4'd0 : r_step;
        w_nxt   = (w_idx == 4'd9) ? 4'd0 : w_idx + 4'd1;
        w_even  = ~w_idx[0];
        w_sel   = r_limb[w_idx];
        w_round = w_sel + (w_even ? HalfEven : HalfOdd);
        w_c     = w_even ? (w_round >>> 26) : (w_round >>> 25);
        w_kept  = w_even ? (w_sel - (w_c <<< 26)) : (w_sel - (w_c <<< 25));
        w_add   = (w_idx == 4'd9) ? ((w_c <<< 4) + (w_c <<< 1) + w_c) : w_c;
        for (int i = 0; i < 10; i++) begin
            w_limb_nxt[i] = r_limb[i];
            if (w_idx == 4'(i)) begin
                w_limb_nxt[i] = w_kept;
            end else if (w_nxt == 4'(i)) begin
                w_limb_nxt[i] = r_limb[i] + w_add;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_step      <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                r_limb[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        for (int i = 0; i < 10; i++) begin
                            r_limb[i] <= INT_W'($signed(f[LIMB_W*i +: LIMB_W]));
                        end
                        r_step     <= 4'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    for (int i = 0; i < 10; i++) begin
                        r_limb[i] <= w_limb_nxt[i];
                    end
                    if (r_step == 4'd10) begin
                        r_step      <= 4'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

    // Normalized limbs always fit in LIMB_W; the guard bits are dropped.
    for (genvar g = 0; g < 10; g++) begin : g_pack
        assign h[LIMB_W*g +: LIMB_W] = r_limb[g][LIMB_W-1:0];
    end

    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w_unused = w_unused ^ (^r_limb[i][INT_W-1:LIMB_W]);
        end
    end

endmodule

// File: tb/tb_fe_carry.sv
// Bench for fe_carry: vector table plus scoreboard, with stall and mid-run reset sequences.
module tb_fe_carry;
    localparam int LIMB_W = 32;
    localparam int INT_W  = 34;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [319:0] f;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] h;

    always #5 clk = ~clk;

    fe_carry #(.LIMB_W(LIMB_W), .INT_W(INT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h         (h)
    );

    typedef struct {
        logic [319:0] f;
        logic [319:0] exp;
        string        name;
    } vec_t;

    typedef struct {
        logic [319:0] exp;
        string        name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    sb_t  sb_cur;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [319:0] lv(input int i, input logic [31:0] v);
        logic [319:0] r;
        r = '0;
        r[32*i +: 32] = v;
        return r;
    endfunction

    // Behavioural reference using 64-bit integer arithmetic.
    function automatic logic [319:0] model(input logic [319:0] fin);
        longint l[10];
        longint c;
        int     k;
        int     b;
        logic [319:0] r;
        for (int i = 0; i < 10; i++) l[i] = longint'($signed(fin[32*i +: 32]));
        for (int s = 0; s < 11; s++) begin
            k = (s == 10) ? 0 : s;
            b = (k % 2 == 0) ? 26 : 25;
            c = (l[k] + (longint'(1) <<< (b - 1))) >>> b;
            l[k] = l[k] - c * (longint'(1) <<< b);
            if (k == 9) l[0] = l[0] + 19 * c;
            else        l[k+1] = l[k+1] + c;
        end
        r = '0;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = l[i][31:0];
        return r;
    endfunction

    task automatic add_vec(input logic [319:0] fv, input logic [319:0] ev, input string nm);
        vec_t v;
        v.f = fv;
        v.exp = ev;
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic push_sb(input logic [319:0] ev, input string nm);
        sb_t s;
        s.exp = ev;
        s.name = nm;
        sb_q.push_back(s);
    endtask

    // Wait for out_valid counting cycles from the accept edge; expects 12.
    task automatic wait_out(input string nm);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, 12);
    endtask

    task automatic send(input logic [319:0] fv, input logic [319:0] ev, input string nm);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        chk({nm, "_in_ready"}, in_ready, 1);
        f = fv;
        in_valid = 1'b1;
        push_sb(ev, nm);
        tick();
        in_valid = 1'b0;
        chk({nm, "_busy"}, in_ready, 0);
        wait_out(nm);
        tick();
        chk({nm, "_ov_pulse"}, out_valid, 0);
        chk({nm, "_ready_back"}, in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_output: got out_valid=1 required no pending result");
            end else begin
                sb_cur = sb_q.pop_front();
                chk(sb_cur.name, h, sb_cur.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [319:0] fr;
        logic [319:0] f1;
        logic [319:0] f2;
        int           cnt;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        f = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_h", h, '0);

        add_vec('0, '0, "zero");
        add_vec(lv(0, 32'h04000000), lv(1, 32'd1), "l0_2p26");
        add_vec(lv(9, 32'h02000000), lv(0, 32'd19), "l9_fold19");
        add_vec(lv(0, 32'h7FFFFFFF), lv(0, 32'hFFFFFFFF) | lv(1, 32'd32), "l0_max");
        add_vec(lv(0, 32'hFFFFFFFF), lv(0, 32'hFFFFFFFF), "l0_neg1");
        add_vec(lv(1, 32'hFE000000), lv(2, 32'hFFFFFFFF), "l1_neg");
        add_vec(lv(9, 32'h80000000), lv(0, 32'hFFFFFB40), "l9_min");
        add_vec(lv(0, 32'h01FFFFFF) | lv(9, 32'h02000000),
                lv(0, 32'hFE000012) | lv(1, 32'd1), "step10_carry");
        for (int i = 0; i < 8; i++) begin
            fr = '0;
            for (int j = 0; j < 10; j++) fr[32*j +: 32] = $urandom;
            add_vec(fr, model(fr), $sformatf("rand%0d", i));
        end

        foreach (vecs[i]) send(vecs[i].f, vecs[i].exp, vecs[i].name);

        // Back-to-back elements with a 5-cycle output stall.
        f1 = lv(0, 32'h7FFFFFFF) | lv(5, 32'h12345678);
        f2 = lv(3, 32'hF0000000) | lv(8, 32'h0ABCDEF0);
        f = f1;
        in_valid = 1'b1;
        push_sb(model(f1), "stall_first");
        tick();
        f = f2;
        out_ready = 1'b0;
        wait_out("stall_first");
        for (int k = 0; k < 5; k++) begin
            chk("stall_h_held", h, model(f1));
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        push_sb(model(f2), "stall_second");
        tick();
        chk("handshake_in_ready", in_ready, 1);
        chk("handshake_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("second_busy", in_ready, 0);
        wait_out("stall_second");
        tick();

        // Reset at step 5 discards the element in flight.
        f = lv(0, 32'h04000000) | lv(4, 32'h00FFFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_h", h, '0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("midrst_no_output", cnt, 0);
        send(lv(0, 32'h04000000), lv(1, 32'd1), "after_rst");

        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
